// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Receive-side decoder for a multiplexed 4-digit 7-segment bus. It watches
//   the scanned digit enables and waits for each enable to settle. It then
//   samples that digit's segment pattern and decodes it back to a hex nibble.
//   Once enough identical complete frames have been seen, it publishes the
//   16-bit value on a valid/ready port.
//
//   Optional feature: define SCAN_TIMEOUT_EN to build the idle/stall detector.
//   Without it, scan_stall is constant 0 and TIMEOUT is ignored.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   en[3:0]        in   digit enables, en[k] selects digit k
//   a..g           in   segment lines
//   out_digits     out  published hex digits, digit3 at [15:12]
//   out_err        out  per-digit flag, published pattern was undecodable
//   out_valid      out  out_digits/out_err hold a new value
//   out_ready      in   consumer accepts when out_valid && out_ready
//   scan_stall     out  scan activity lost (SCAN_TIMEOUT_EN only)

module seg7_scan_decoder #(
    parameter int SETTLE         = 2,
    parameter int STABLE_FRAMES  = 2,
    parameter int EN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int TIMEOUT        = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  en,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic [15:0] out_digits,
    output logic [3:0]  out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        scan_stall
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);

    // Returns {err, nibble}; any pattern outside the table decodes to 0 with err set.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h7E: seg_decode = 5'h00;
            7'h30: seg_decode = 5'h01;
            7'h6D: seg_decode = 5'h02;
            7'h79: seg_decode = 5'h03;
            7'h33: seg_decode = 5'h04;
            7'h5B: seg_decode = 5'h05;
            7'h5F: seg_decode = 5'h06;
            7'h70: seg_decode = 5'h07;
            7'h7F: seg_decode = 5'h08;
            7'h7B: seg_decode = 5'h09;
            7'h77: seg_decode = 5'h0A;
            7'h1F: seg_decode = 5'h0B;
            7'h4E: seg_decode = 5'h0C;
            7'h3D: seg_decode = 5'h0D;
            7'h4F: seg_decode = 5'h0E;
            7'h47: seg_decode = 5'h0F;
            default: seg_decode = 5'h10;
        endcase
    endfunction

    logic [3:0]    en_q, en_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    en_prev_q, en_prev_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          done_q, done_d;
    logic [15:0]   cap_dig_q, cap_dig_d;
    logic [3:0]    cap_err_q, cap_err_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   prev_dig_q, prev_dig_d;
    logic [3:0]    prev_err_q, prev_err_d;
    logic [MW-1:0] match_q, match_d;
    logic          published_q, published_d;
    logic [15:0]   out_digits_q, out_digits_d;
    logic [3:0]    out_err_q, out_err_d;
    logic          out_valid_q, out_valid_d;

    logic [3:0]    en_n;
    logic [6:0]    seg_n;
    logic [4:0]    dec;
    logic [1:0]    slot;
    logic          sample;
    logic          frame_done;
    logic          publish;

`ifdef SCAN_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          stall_q, stall_d;
`endif

    always_comb begin
        en_d  = en;
        seg_d = {a, b, c, d, e, f, g};
        en_n  = (EN_ACTIVE_LOW != 0) ? ~en_q : en_q;
        seg_n = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
        dec   = seg_decode(seg_n);

        case (en_n)
            4'b0001: slot = 2'd0;
            4'b0010: slot = 2'd1;
            4'b0100: slot = 2'd2;
            default: slot = 2'd3;
        endcase

        // settle_d counts cycles the current one-hot enable has been held,
        // including this one; done_d limits sampling to once per dwell.
        en_prev_d = en_n;
        settle_d  = '0;
        done_d    = 1'b0;
        sample    = 1'b0;
        if ($onehot(en_n)) begin
            if (en_n != en_prev_q) begin
                settle_d = SW'(1);
            end else begin
                settle_d = (settle_q == SW'(SETTLE)) ? settle_q : settle_q + 1'b1;
                done_d   = done_q;
            end
            if (!done_d && settle_d == SW'(SETTLE)) begin
                sample = 1'b1;
                done_d = 1'b1;
            end
        end

        cap_dig_d = cap_dig_q;
        cap_err_d = cap_err_q;
        mask_d    = mask_q;
        if (sample) begin
            cap_dig_d[4*slot +: 4] = dec[3:0];
            cap_err_d[slot]        = dec[4];
            mask_d[slot]           = 1'b1;
        end

        // Frame comparison uses the slot being written this cycle, so the
        // mask clears on the completing sample itself.
        frame_done = (mask_d == 4'hF);
        prev_dig_d = prev_dig_q;
        prev_err_d = prev_err_q;
        match_d    = match_q;
        if (frame_done) begin
            mask_d = 4'h0;
            if (match_q != '0 && cap_dig_d == prev_dig_q && cap_err_d == prev_err_q) begin
                match_d = (match_q == MW'(STABLE_FRAMES)) ? match_q : match_q + 1'b1;
            end else begin
                match_d    = MW'(1);
                prev_dig_d = cap_dig_d;
                prev_err_d = cap_err_d;
            end
        end

        publish = frame_done && (match_d == MW'(STABLE_FRAMES)) &&
                  (!published_q || cap_dig_d != out_digits_q || cap_err_d != out_err_q);

        published_d  = published_q | publish;
        out_digits_d = publish ? cap_dig_d : out_digits_q;
        out_err_d    = publish ? cap_err_d : out_err_q;
        out_valid_d  = out_valid_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (publish)                  out_valid_d = 1'b1;

`ifdef SCAN_TIMEOUT_EN
        stall_d = stall_q;
        if (sample) begin
            idle_d  = '0;
            stall_d = 1'b0;
        end else begin
            idle_d = (idle_q == IW'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
        end
        // A stalled scan abandons any partial frame and the match history,
        // but the last published value stays on the outputs.
        if (idle_d == IW'(TIMEOUT)) begin
            stall_d = 1'b1;
            mask_d  = 4'h0;
            match_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= '0;
            seg_q        <= '0;
            en_prev_q    <= '0;
            settle_q     <= '0;
            done_q       <= 1'b0;
            cap_dig_q    <= '0;
            cap_err_q    <= '0;
            mask_q       <= '0;
            prev_dig_q   <= '0;
            prev_err_q   <= '0;
            match_q      <= '0;
            published_q  <= 1'b0;
            out_digits_q <= '0;
            out_err_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            en_q         <= en_d;
            seg_q        <= seg_d;
            en_prev_q    <= en_prev_d;
            settle_q     <= settle_d;
            done_q       <= done_d;
            cap_dig_q    <= cap_dig_d;
            cap_err_q    <= cap_err_d;
            mask_q       <= mask_d;
            prev_dig_q   <= prev_dig_d;
            prev_err_q   <= prev_err_d;
            match_q      <= match_d;
            published_q  <= published_d;
            out_digits_q <= out_digits_d;
            out_err_q    <= out_err_d;
            out_valid_q  <= out_valid_d;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            idle_q  <= idle_d;
            stall_q <= stall_d;
        end
    end

    assign scan_stall = stall_q;
`else
    assign scan_stall = 1'b0;
`endif

    assign out_digits = out_digits_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;

endmodule
